// File: rtl/ofm_wb_pkg.sv
// ============================================================================
// ofm_wb_pkg: shared types, word geometry and lane helpers for ofm_pack_writeback
// Rev 1.0
// ============================================================================
`default_nettype none

package ofm_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_PE = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = NUM_PE * BYTE_W;

  // Bit offset of a PE's byte lane inside the packed word (PE0 at the LSB).
  function automatic int lane_lo(input int lane);
    return lane * BYTE_W;
  endfunction

  function automatic logic [BYTE_W-1:0] relu8(input logic [BYTE_W-1:0] b);
    return b[BYTE_W-1] ? '0 : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ofm_wb_fifo.sv
// ============================================================================
// ofm_wb_fifo: packed-word FIFO; a push is accepted while full if a pop happens
// on the same edge. Rev 1.0
// ============================================================================
`default_nettype none

module ofm_wb_fifo
  import ofm_wb_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/ofm_pack_writeback.sv
// ============================================================================
// ofm_pack_writeback: packs 16 PE OFM bytes into 128-bit words and writes them
// to the global BRAM port. Optional macro OFM_WB_RELU_EN zeroes negative bytes.
// Rev 1.0
// ============================================================================
`default_nettype none

module ofm_pack_writeback #(
  parameter int NUM_PE     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_words,
  input  logic [NUM_PE-1:0]   pe_finish,
  input  logic [8*NUM_PE-1:0] ofm_in,
  input  logic                wr_grant,
  output logic                we,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [8*NUM_PE-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                proto_err
);

  import ofm_wb_pkg::*;

  state_e             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_PE-1:0]  mask_q;
  logic [NUM_PE-1:0]  mask_d;
  logic [BYTE_W-1:0]  stage_q [NUM_PE];
  logic [BYTE_W-1:0]  stage_d [NUM_PE];
  logic               we_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [WORD_W-1:0]  wr_data_q;
  logic               busy_q;
  logic               done_q;
  logic               overflow_q;
  logic               proto_err_q;

  logic [BYTE_W-1:0]  w_cap [NUM_PE];
  logic [NUM_PE-1:0]  w_fin;
  logic [WORD_W-1:0]  w_merged;
  logic [WORD_W-1:0]  w_head;
  logic               w_run;
  logic               w_complete;
  logic               w_refire;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_last;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
`ifdef OFM_WB_RELU_EN
    assign w_cap[i] = relu8(ofm_in[lane_lo(i) +: BYTE_W]);
`else
    assign w_cap[i] = ofm_in[lane_lo(i) +: BYTE_W];
`endif
  end

  always_comb begin
    w_run      = (state_q == RUN);
    w_fin      = w_run ? pe_finish : '0;
    w_complete = w_run && (&(mask_q | pe_finish));
    w_refire   = (|(mask_q & w_fin)) && !w_complete;
    w_push     = w_complete;
    w_pop      = w_run && wr_grant && !w_empty;
    w_last     = ((cnt_q + 1'b1) == num_q);
    w_merged   = '0;
    stage_d    = stage_q;
    for (int i = 0; i < NUM_PE; i++) begin
      // Bytes arriving on the completing edge override anything staged earlier.
      w_merged[lane_lo(i) +: BYTE_W] = w_fin[i] ? w_cap[i] : stage_q[i];
      if (w_fin[i]) stage_d[i] = w_cap[i];
    end
    if (!w_run || w_complete) mask_d = '0;
    else                      mask_d = mask_q | w_fin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_PE; i++) stage_q[i] <= '0;
    end else begin
      mask_q  <= mask_d;
      stage_q <= stage_d;
    end
  end

  // Leaving RUN discards any buffered residue.
  ofm_wb_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (!w_run),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_merged),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            num_q       <= num_words;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            if (num_words == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_push && w_full && !w_pop) overflow_q  <= 1'b1;
          if (w_refire)                   proto_err_q <= 1'b1;
          if (w_pop) begin
            we_q      <= 1'b1;
            wr_addr_q <= base_q + ADDR_W'(cnt_q);
            wr_data_q <= w_head;
            cnt_q     <= cnt_q + 1'b1;
            if (w_last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign we        = we_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ofm_pack_writeback.sv
// ============================================================================
// tb_ofm_pack_writeback: directed self-checking bench for ofm_pack_writeback.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ofm_pack_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_words;
  logic [15:0]  pe_finish;
  logic [127:0] ofm_in;
  logic         wr_grant;
  logic         we;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         busy;
  logic         done;
  logic         overflow;
  logic         proto_err;

  int total = 0;
  int bad   = 0;

  ofm_pack_writeback #(
    .NUM_PE     (16),
    .FIFO_DEPTH (4),
    .ADDR_W     (32),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .pe_finish (pe_finish),
    .ofm_in    (ofm_in),
    .wr_grant  (wr_grant),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    tick;
    start = 1'b0;
  endtask

  task automatic fire(input logic [15:0] m, input logic [127:0] d);
    pe_finish = m; ofm_in = d;
    tick;
    pe_finish = '0; ofm_in = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    pe_finish = '0; ofm_in = '0; wr_grant = 1'b0;
    tick; tick;
    total++; if (we !== 1'b0)        begin bad++; $display("FAIL rst_we got=%0h exp=0", we); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%0h exp=0", done); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL rst_ovf got=%0h exp=0", overflow); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_perr got=%0h exp=0", proto_err); end
    total++; if (wr_addr !== 32'h0)  begin bad++; $display("FAIL rst_addr got=%0h exp=0", wr_addr); end
    total++; if (wr_data !== 128'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", wr_data); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    wr_grant = 1'b1;
    do_start(32'h100, 16'd2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0h exp=1", busy); end
    fire(16'hFFFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL basic_we_early got=%0h exp=0", we); end
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL basic_we0 got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'h100) begin bad++; $display("FAIL basic_addr0 got=%0h exp=100", wr_addr); end
    total++; if (wr_data !== 128'h0F0E0D0C_0B0A0908_07060504_03020100)
      begin bad++; $display("FAIL basic_data0 got=%0h exp=0f0e..00", wr_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%0h exp=0", done); end
    fire(16'hFFFF, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL basic_we_gap got=%0h exp=0", we); end
    total++; if (wr_addr !== 32'h100) begin bad++; $display("FAIL basic_addr_hold got=%0h exp=100", wr_addr); end
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL basic_we1 got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'h101) begin bad++; $display("FAIL basic_addr1 got=%0h exp=101", wr_addr); end
    total++; if (wr_data !== 128'h1F1E1D1C_1B1A1918_17161514_13121110)
      begin bad++; $display("FAIL basic_data1 got=%0h exp=1f1e..10", wr_data); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0h exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_off got=%0h exp=0", busy); end
    tick;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%0h exp=0", done); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL basic_we_after got=%0h exp=0", we); end
  endtask

  task automatic test_split;
    wr_grant = 1'b1;
    do_start(32'h200, 16'd1);
    do_start(32'h999, 16'd7);
    fire(16'h00FF, {64'hDEADBEEF_DEADBEEF, 64'h27262524_23222120});
    tick; tick;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL split_we_partial got=%0h exp=0", we); end
    fire(16'hFF00, {64'h2F2E2D2C_2B2A2928, 64'hFFFFFFFF_FFFFFFFF});
    total++; if (we !== 1'b0) begin bad++; $display("FAIL split_we_t1 got=%0h exp=0", we); end
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL split_we_t2 got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'h200) begin bad++; $display("FAIL split_addr got=%0h exp=200", wr_addr); end
    total++; if (wr_data !== 128'h2F2E2D2C_2B2A2928_27262524_23222120)
      begin bad++; $display("FAIL split_data got=%0h exp=2f2e..20", wr_data); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL split_done got=%0h exp=1", done); end
    tick;
  endtask

  task automatic test_back_to_back;
    wr_grant = 1'b1;
    do_start(32'hFFFF_FFFF, 16'd2);
    fire(16'hFFFF, {16{8'hA1}});
    fire(16'hFFFF, {16{8'hB2}});
    total++; if (we !== 1'b1) begin bad++; $display("FAIL b2b_we0 got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_addr0 got=%0h exp=ffffffff", wr_addr); end
    total++; if (wr_data !== {16{8'hA1}}) begin bad++; $display("FAIL b2b_data0 got=%0h exp=a1..", wr_data); end
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL b2b_we1 got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL b2b_addr_wrap got=%0h exp=0", wr_addr); end
    total++; if (wr_data !== {16{8'hB2}}) begin bad++; $display("FAIL b2b_data1 got=%0h exp=b2..", wr_data); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%0h exp=1", done); end
    tick;
  endtask

  task automatic test_zero_words;
    do_start(32'h800, 16'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0h exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%0h exp=0", busy); end
    tick;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%0h exp=0", done); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL zero_we got=%0h exp=0", we); end
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    wr_grant = 1'b0;
    do_start(32'h300, 16'd5);
    for (int k = 0; k < 5; k++) begin
      b = 8'h40 + 8'(k);
      fire(16'hFFFF, {16{b}});
      if (k == 3) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0h exp=0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h exp=1", overflow); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL ovf_stall_we got=%0h exp=0", we); end
    wr_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      b = 8'h40 + 8'(k);
      total++; if (we !== 1'b1) begin bad++; $display("FAIL ovf_we%0d got=%0h exp=1", k, we); end
      total++; if (wr_addr !== 32'h300 + 32'(k))
        begin bad++; $display("FAIL ovf_addr%0d got=%0h exp=%0h", k, wr_addr, 32'h300 + 32'(k)); end
      total++; if (wr_data !== {16{b}}) begin bad++; $display("FAIL ovf_data%0d got=%0h exp=%0h", k, wr_data, {16{b}}); end
    end
    tick;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL ovf_drained_we got=%0h exp=0", we); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ovf_no_done got=%0h exp=0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_still_busy got=%0h exp=1", busy); end
    fire(16'hFFFF, {16{8'h50}});
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL ovf_last_we got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'h304) begin bad++; $display("FAIL ovf_last_addr got=%0h exp=304", wr_addr); end
    total++; if (wr_data !== {16{8'h50}}) begin bad++; $display("FAIL ovf_last_data got=%0h exp=50..", wr_data); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%0h exp=1", done); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
    tick;
  endtask

  task automatic test_proto;
    wr_grant = 1'b1;
    do_start(32'h400, 16'd1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL proto_ovf_clr got=%0h exp=0", overflow); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_clr got=%0h exp=0", proto_err); end
    fire(16'h0008, 128'h33000000);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_first got=%0h exp=0", proto_err); end
    fire(16'h0008, 128'hAA000000);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%0h exp=1", proto_err); end
    fire(16'hFFF7, 128'h6F6E6D6C_6B6A6968_67666564_55626160);
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL proto_we got=%0h exp=1", we); end
    total++; if (wr_data !== 128'h6F6E6D6C_6B6A6968_67666564_AA626160)
      begin bad++; $display("FAIL proto_lane3 got=%0h exp=..aa626160", wr_data); end
    tick;
  endtask

  task automatic test_midrun_reset;
    wr_grant = 1'b0;
    do_start(32'h500, 16'd4);
    fire(16'hFFFF, {16{8'h71}});
    fire(16'hFFFF, {16{8'h72}});
    wr_grant = 1'b1;
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL mrst_pre_we got=%0h exp=1", we); end
    #2 reset = 1'b1;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mrst_we got=%0h exp=0", we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mrst_done got=%0h exp=0", done); end
    total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL mrst_addr got=%0h exp=0", wr_addr); end
    tick; tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (we !== 1'b0) begin bad++; $display("FAIL mrst_quiet%0d got=%0h exp=0", k, we); end
    end
    do_start(32'h600, 16'd1);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL mrst_no_residue got=%0h exp=0", we); end
    fire(16'hFFFF, {16{8'h11}});
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL mrst_restart_we got=%0h exp=1", we); end
    total++; if (wr_addr !== 32'h600) begin bad++; $display("FAIL mrst_restart_addr got=%0h exp=600", wr_addr); end
    total++; if (wr_data !== {16{8'h11}}) begin bad++; $display("FAIL mrst_restart_data got=%0h exp=11..", wr_data); end
    tick;
  endtask

  task automatic test_relu;
    logic [127:0] exp_w;
`ifdef OFM_WB_RELU_EN
    exp_w = 128'h01010101_01010101_01010001_7F000101;
`else
    exp_w = 128'h01010101_01010101_0101FF01_7F800101;
`endif
    wr_grant = 1'b1;
    do_start(32'h700, 16'd1);
    fire(16'hFFFF, 128'h01010101_01010101_0101FF01_7F800101);
    tick;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL relu_we got=%0h exp=1", we); end
    total++; if (wr_data !== exp_w) begin bad++; $display("FAIL relu_lanes got=%0h exp=%0h", wr_data, exp_w); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_split;
    test_back_to_back;
    test_zero_words;
    test_overflow;
    test_proto;
    test_midrun_reset;
    test_relu;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
